// File: rtl/cache_assoc_wb.sv
// cache_assoc_wb: N-way set-associative, write-back, write-allocate data cache
// between a core load/store port and a block-wide memory port.
// Optional feature macro: CACHE_ASSOC_PERF_CNT_EN adds perf_access/perf_miss counters.
module cache_assoc_wb #(
    parameter int ADDR_WIDTH      = 32,
    parameter int WORD_WIDTH      = 32,
    parameter int NUM_WAYS        = 4,
    parameter int NUM_LINES       = 64,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  proc_cs,
    input  logic                                  proc_rw,
    input  logic [ADDR_WIDTH-1:0]                 proc_addr,
    input  logic [WORD_WIDTH-1:0]                 proc_wdata,
    input  logic [WORD_WIDTH/8-1:0]               proc_be,
    input  logic                                  proc_flush,
    output logic [WORD_WIDTH-1:0]                 proc_rdata,
    output logic                                  proc_hold,
    output logic                                  mem_cs,
    output logic                                  mem_rw,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] mem_wdata,
    input  logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] mem_rdata,
    input  logic                                  mem_ack
`ifdef CACHE_ASSOC_PERF_CNT_EN
    ,
    output logic [31:0]                           perf_access,
    output logic [31:0]                           perf_miss
`endif
);

    localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
    localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int BLK_W  = WORD_WIDTH * WORDS_PER_BLOCK;
    localparam int BE_W   = WORD_WIDTH / 8;

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_VICTIM  = 3'd2;
    localparam logic [2:0] S_WB      = 3'd3;
    localparam logic [2:0] S_FILL    = 3'd4;
    localparam logic [2:0] S_FL_SCAN = 3'd5;
    localparam logic [2:0] S_FL_WB   = 3'd6;

    // Cache storage, indexed [line][way]
    logic [NUM_WAYS-1:0] valid_q [NUM_LINES];
    logic [NUM_WAYS-1:0] dirty_q [NUM_LINES];
    logic [TAG_W-1:0]    tag_q   [NUM_LINES][NUM_WAYS];
    logic [BLK_W-1:0]    data_q  [NUM_LINES][NUM_WAYS];
    logic [WAY_W-1:0]    rr_q    [NUM_LINES];

    logic [2:0]            state_q,   state_d;
    logic [IDX_W-1:0]      cnt_idx_q, cnt_idx_d;   // INIT and FLUSH index walker
    logic [WAY_W-1:0]      fl_way_q,  fl_way_d;
    logic [TAG_W-1:0]      req_tag_q, req_tag_d;
    logic [IDX_W-1:0]      req_idx_q, req_idx_d;
    logic [WAY_W-1:0]      vic_way_q, vic_way_d;
    logic                  vic_rr_q,  vic_rr_d;
    logic [TAG_W-1:0]      wb_tag_q,  wb_tag_d;
    logic [IDX_W-1:0]      wb_idx_q,  wb_idx_d;
    logic [BLK_W-1:0]      wb_buf_q,  wb_buf_d;
    logic [WORD_WIDTH-1:0] rdata_q,   rdata_d;

    logic [TAG_W-1:0]      a_tag;
    logic [IDX_W-1:0]      a_idx;
    logic [OFF_WS-1:0]     a_off;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [BLK_W-1:0]      hit_blk;
    logic [BLK_W-1:0]      wr_blk;
    logic [WORD_WIDTH-1:0] hit_word;
    logic                  inv_found;
    logic [WAY_W-1:0]      inv_way;
    logic [WAY_W-1:0]      rr_way;
    logic                  hold_c;
    logic                  fl_step;
    logic                  fl_last;
    logic                  idle_req;

    assign a_tag    = proc_addr[ADDR_WIDTH-1 -: TAG_W];
    assign a_idx    = proc_addr[OFF_W +: IDX_W];
    assign a_off    = (OFF_W == 0) ? '0 : proc_addr[OFF_WS-1:0];
    assign idle_req = (state_q == S_IDLE) && !proc_flush && proc_cs;
    assign rr_way   = rr_q[req_idx_q];
    assign fl_last  = (fl_way_q == WAY_W'(NUM_WAYS-1)) && (cnt_idx_q == IDX_W'(NUM_LINES-1));

    // Tag lookup across all ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[a_idx][w] && (tag_q[a_idx][w] == a_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Hit word extraction and byte-enable merge of the write data into the block
    always_comb begin
        hit_blk  = data_q[a_idx][hit_way];
        hit_word = hit_blk[a_off*WORD_WIDTH +: WORD_WIDTH];
        wr_blk   = hit_blk;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (proc_be[b]) begin
                wr_blk[a_off*WORD_WIDTH + b*8 +: 8] = proc_wdata[b*8 +: 8];
            end
        end
    end

    // Victim search: lowest-numbered invalid way in the missed set
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!inv_found && !valid_q[req_idx_q][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    // Controller next-state and stall logic
    always_comb begin
        state_d   = state_q;
        cnt_idx_d = cnt_idx_q;
        fl_way_d  = fl_way_q;
        req_tag_d = req_tag_q;
        req_idx_d = req_idx_q;
        vic_way_d = vic_way_q;
        vic_rr_d  = vic_rr_q;
        wb_tag_d  = wb_tag_q;
        wb_idx_d  = wb_idx_q;
        wb_buf_d  = wb_buf_q;
        rdata_d   = rdata_q;
        hold_c    = 1'b1;
        fl_step   = 1'b0;
        case (state_q)
            S_INIT: begin
                if (cnt_idx_q == IDX_W'(NUM_LINES-1)) begin
                    cnt_idx_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_idx_d = cnt_idx_q + IDX_W'(1);
                end
            end
            S_IDLE: begin
                if (proc_flush) begin
                    cnt_idx_d = '0;
                    fl_way_d  = '0;
                    state_d   = S_FL_SCAN;
                end else if (proc_cs) begin
                    if (hit) begin
                        hold_c = 1'b0;
                        if (!proc_rw) begin
                            rdata_d = hit_word;
                        end
                    end else begin
                        req_tag_d = a_tag;
                        req_idx_d = a_idx;
                        state_d   = S_VICTIM;
                    end
                end else begin
                    hold_c = 1'b0;
                end
            end
            S_VICTIM: begin
                vic_way_d = inv_found ? inv_way : rr_way;
                vic_rr_d  = !inv_found;
                if (!inv_found && valid_q[req_idx_q][rr_way] && dirty_q[req_idx_q][rr_way]) begin
                    wb_tag_d = tag_q[req_idx_q][rr_way];
                    wb_idx_d = req_idx_q;
                    wb_buf_d = data_q[req_idx_q][rr_way];
                    state_d  = S_WB;
                end else begin
                    state_d  = S_FILL;
                end
            end
            S_WB: begin
                if (mem_ack) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_FL_SCAN: begin
                if (valid_q[cnt_idx_q][fl_way_q] && dirty_q[cnt_idx_q][fl_way_q]) begin
                    wb_tag_d = tag_q[cnt_idx_q][fl_way_q];
                    wb_idx_d = cnt_idx_q;
                    wb_buf_d = data_q[cnt_idx_q][fl_way_q];
                    state_d  = S_FL_WB;
                end else begin
                    fl_step = 1'b1;
                end
            end
            S_FL_WB: begin
                if (mem_ack) begin
                    fl_step = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
        // Advance the flush walker way-first, then index; leave once the last entry is done
        if (fl_step) begin
            if (fl_way_q == WAY_W'(NUM_WAYS-1)) begin
                fl_way_d  = '0;
                cnt_idx_d = cnt_idx_q + IDX_W'(1);
            end else begin
                fl_way_d  = fl_way_q + WAY_W'(1);
            end
            state_d = fl_last ? S_IDLE : S_FL_SCAN;
        end
    end

    // Controller registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            cnt_idx_q <= '0;
            fl_way_q  <= '0;
            req_tag_q <= '0;
            req_idx_q <= '0;
            vic_way_q <= '0;
            vic_rr_q  <= 1'b0;
            wb_tag_q  <= '0;
            wb_idx_q  <= '0;
            wb_buf_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_idx_q <= cnt_idx_d;
            fl_way_q  <= fl_way_d;
            req_tag_q <= req_tag_d;
            req_idx_q <= req_idx_d;
            vic_way_q <= vic_way_d;
            vic_rr_q  <= vic_rr_d;
            wb_tag_q  <= wb_tag_d;
            wb_idx_q  <= wb_idx_d;
            wb_buf_q  <= wb_buf_d;
            rdata_q   <= rdata_d;
        end
    end

    // Round-robin replacement pointers, advanced only when the victim came from them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                rr_q[i] <= '0;
            end
        end else if ((state_q == S_FILL) && mem_ack && vic_rr_q) begin
            rr_q[req_idx_q] <= (rr_q[req_idx_q] == WAY_W'(NUM_WAYS-1)) ? '0
                                                                       : rr_q[req_idx_q] + WAY_W'(1);
        end
    end

    // Cache arrays; valid/dirty are cleared by the INIT walk, so no reset is needed here
    always_ff @(posedge clk) begin
        case (state_q)
            S_INIT: begin
                valid_q[cnt_idx_q] <= '0;
                dirty_q[cnt_idx_q] <= '0;
            end
            S_IDLE: begin
                if (idle_req && hit && proc_rw) begin
                    data_q[a_idx][hit_way]  <= wr_blk;
                    dirty_q[a_idx][hit_way] <= 1'b1;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    data_q[req_idx_q][vic_way_q]  <= mem_rdata;
                    tag_q[req_idx_q][vic_way_q]   <= req_tag_q;
                    valid_q[req_idx_q][vic_way_q] <= 1'b1;
                    dirty_q[req_idx_q][vic_way_q] <= 1'b0;
                end
            end
            S_FL_SCAN, S_FL_WB: begin
                if (fl_step) begin
                    valid_q[cnt_idx_q][fl_way_q] <= 1'b0;
                    dirty_q[cnt_idx_q][fl_way_q] <= 1'b0;
                end
            end
            default: ;
        endcase
    end

`ifdef CACHE_ASSOC_PERF_CNT_EN
    logic [31:0] perf_access_q;
    logic [31:0] perf_miss_q;

    // Access/miss counters, free-running with natural wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_access_q <= '0;
            perf_miss_q   <= '0;
        end else if (idle_req) begin
            if (hit) begin
                perf_access_q <= perf_access_q + 32'd1;
            end else begin
                perf_miss_q   <= perf_miss_q + 32'd1;
            end
        end
    end

    assign perf_access = perf_access_q;
    assign perf_miss   = perf_miss_q;
`endif

    // mem_cs drops combinationally with mem_ack so a request is never seen twice
    assign mem_cs     = ((state_q == S_WB) || (state_q == S_FILL) || (state_q == S_FL_WB)) && !mem_ack;
    assign mem_rw     = (state_q == S_WB) || (state_q == S_FL_WB);
    assign mem_addr   = ((state_q == S_WB) || (state_q == S_FL_WB)) ? (ADDR_WIDTH'({wb_tag_q, wb_idx_q}) << OFF_W) :
                        (state_q == S_FILL) ? (ADDR_WIDTH'({req_tag_q, req_idx_q}) << OFF_W) : '0;
    assign mem_wdata  = wb_buf_q;
    assign proc_rdata = rdata_q;
    assign proc_hold  = hold_c;

endmodule
